// File: rtl/alu_cmd_framer_pkg.sv
// Shared types and defaults for the ALU command framer (package alu_frame_pkg).
// Checksum support is selected at build time with ALU_FRAME_CHECKSUM_EN.
package alu_frame_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF      = 8'hA5;
    localparam int         TIMEOUT_CYCLES_DEF = 1_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_A,
        ST_GET_B,
        ST_GET_OP,
        ST_GET_CK,
        ST_EXEC,
        ST_SEND_RES,
        ST_SEND_CK
    } state_t;

    // CK covers the full OP byte, not just the opcode bits forwarded to the ALU.
    function automatic logic [7:0] frame_ck(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] op);
        return a ^ b ^ op;
    endfunction

endpackage

// File: rtl/alu_cmd_framer_if.sv
// UART FIFO, ALU and status signals of the command framer.
// Handshakes: a byte moves on a cycle where o_rd_uart=1 (head valid while i_rx_empty=0), and o_wr_uart=1 only while i_tx_full=0.
interface alu_cmd_framer_if
    import alu_frame_pkg::*;
#(
    parameter int BUS_SIZE = 8,
    parameter int OPCODE_W = 6
) ();

    logic [BUS_SIZE-1:0] i_rx_data;
    logic                i_rx_empty;
    logic                o_rd_uart;
    logic                i_tx_full;
    logic [BUS_SIZE-1:0] o_tx_data;
    logic                o_wr_uart;
    logic [BUS_SIZE-1:0] o_op_a;
    logic [BUS_SIZE-1:0] o_op_b;
    logic [OPCODE_W-1:0] o_op_code;
    logic [BUS_SIZE-1:0] i_alu_result;
    logic                o_frame_err;
    logic                o_busy;
    state_t              o_state;

    modport slave (
        input  i_rx_data, i_rx_empty, i_tx_full, i_alu_result,
        output o_rd_uart, o_tx_data, o_wr_uart, o_op_a, o_op_b, o_op_code,
               o_frame_err, o_busy, o_state
    );

    modport master (
        output i_rx_data, i_rx_empty, i_tx_full, i_alu_result,
        input  o_rd_uart, o_tx_data, o_wr_uart, o_op_a, o_op_b, o_op_code,
               o_frame_err, o_busy, o_state
    );

endinterface

// File: rtl/alu_cmd_framer_timer.sv
// Inter-byte timeout counter: clears on i_clr, counts while i_en, pulses o_expired
// on its terminal count and restarts from zero.
module frame_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TIMEOUT_W      = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 w_term;

    assign w_term    = i_en && (r_cnt == LAST);
    assign o_expired = w_term;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr || w_term) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_framer.sv
// Sync-hunting command framer: SYNC,A,B,OP[,CK] from the UART RX FIFO to the ALU, result back to TX.
// Build option ALU_FRAME_CHECKSUM_EN adds the CK byte, shadowed operands and the SEND_CK reply byte.
module alu_cmd_framer
    import alu_frame_pkg::*;
#(
    parameter int                  BUS_SIZE       = 8,
    parameter int                  OPCODE_W       = 6,
    parameter logic [BUS_SIZE-1:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int                  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int                  TIMEOUT_W      = 20
) (
    input logic            clk,
    input logic            reset,
    alu_cmd_framer_if.slave bus
);

    state_t              r_state;
    state_t              w_next;
    logic                w_pop;
    logic                w_wr;
    logic                w_err;
    logic                w_wait_byte;
    logic                w_expired;
    logic [BUS_SIZE-1:0] r_tx_data;
    logic [BUS_SIZE-1:0] r_op_a;
    logic [BUS_SIZE-1:0] r_op_b;
    logic [OPCODE_W-1:0] r_op_code;

`ifdef ALU_FRAME_CHECKSUM_EN
    logic [BUS_SIZE-1:0] r_sh_a;
    logic [BUS_SIZE-1:0] r_sh_b;
    logic [BUS_SIZE-1:0] r_sh_op;
    logic                w_ck_ok;

    assign w_ck_ok = (bus.i_rx_data == frame_ck(r_sh_a, r_sh_b, r_sh_op));
`endif

    assign w_wait_byte = (r_state == ST_GET_A) || (r_state == ST_GET_B) ||
                         (r_state == ST_GET_OP) || (r_state == ST_GET_CK);

    frame_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_W     (TIMEOUT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_pop),
        .i_en     (w_wait_byte),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A byte present in the same cycle as expiry is consumed and suppresses the error.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_wr   = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.i_rx_empty) begin
                    w_pop = 1'b1;
                    if (bus.i_rx_data == SYNC_BYTE) w_next = ST_GET_A;
                end
            end
            ST_GET_A, ST_GET_B, ST_GET_OP: begin
                if (!bus.i_rx_empty) begin
                    w_pop = 1'b1;
                    if (r_state == ST_GET_A)      w_next = ST_GET_B;
                    else if (r_state == ST_GET_B) w_next = ST_GET_OP;
`ifdef ALU_FRAME_CHECKSUM_EN
                    else                          w_next = ST_GET_CK;
`else
                    else                          w_next = ST_EXEC;
`endif
                end else if (w_expired) begin
                    w_err  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
`ifdef ALU_FRAME_CHECKSUM_EN
            ST_GET_CK: begin
                if (!bus.i_rx_empty) begin
                    w_pop = 1'b1;
                    if (w_ck_ok) begin
                        w_next = ST_EXEC;
                    end else begin
                        w_err  = 1'b1;
                        w_next = ST_IDLE;
                    end
                end else if (w_expired) begin
                    w_err  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_SEND_CK: begin
                if (!bus.i_tx_full) begin
                    w_wr   = 1'b1;
                    w_next = ST_IDLE;
                end
            end
`endif
            ST_EXEC: begin
                w_next = ST_SEND_RES;
            end
            ST_SEND_RES: begin
                if (!bus.i_tx_full) begin
                    w_wr = 1'b1;
`ifdef ALU_FRAME_CHECKSUM_EN
                    w_next = ST_SEND_CK;
`else
                    w_next = ST_IDLE;
`endif
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_code <= '0;
            r_tx_data <= '0;
`ifdef ALU_FRAME_CHECKSUM_EN
            r_sh_a    <= '0;
            r_sh_b    <= '0;
            r_sh_op   <= '0;
`endif
        end else begin
`ifdef ALU_FRAME_CHECKSUM_EN
            // Operands only become visible once the CK byte proves the frame good.
            if (w_pop && r_state == ST_GET_A)  r_sh_a  <= bus.i_rx_data;
            if (w_pop && r_state == ST_GET_B)  r_sh_b  <= bus.i_rx_data;
            if (w_pop && r_state == ST_GET_OP) r_sh_op <= bus.i_rx_data;
            if (w_pop && r_state == ST_GET_CK && w_ck_ok) begin
                r_op_a    <= r_sh_a;
                r_op_b    <= r_sh_b;
                r_op_code <= r_sh_op[OPCODE_W-1:0];
            end
            if (w_wr && r_state == ST_SEND_RES) r_tx_data <= r_tx_data ^ SYNC_BYTE;
`else
            if (w_pop && r_state == ST_GET_A)  r_op_a    <= bus.i_rx_data;
            if (w_pop && r_state == ST_GET_B)  r_op_b    <= bus.i_rx_data;
            if (w_pop && r_state == ST_GET_OP) r_op_code <= bus.i_rx_data[OPCODE_W-1:0];
`endif
            if (r_state == ST_EXEC) r_tx_data <= bus.i_alu_result;
        end
    end

    // IDLE pops whenever data waits, so the pop is masked while reset is held.
    assign bus.o_rd_uart   = w_pop & ~reset;
    assign bus.o_wr_uart   = w_wr;
    assign bus.o_frame_err = w_err;
    assign bus.o_busy      = (r_state != ST_IDLE);
    assign bus.o_state     = r_state;
    assign bus.o_tx_data   = r_tx_data;
    assign bus.o_op_a      = r_op_a;
    assign bus.o_op_b      = r_op_b;
    assign bus.o_op_code   = r_op_code;

endmodule
